// File: rtl/noc_run_ctrl.sv
// noc_run_ctrl: sequences a torus NoC benchmark run (reset, inject, drain)
// and tracks the number of packets inside the network to give a verdict.
// Optional peak in-flight tracking is compiled in with NOC_RUN_STATS_EN.
module noc_run_ctrl #(
    parameter int CH        = 16,
    parameter int RST_CYC   = 2,
    parameter int RUN_CYC   = 1600,
    parameter int DRAIN_MAX = 256,
    parameter int IF_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CH-1:0]   inj,
    input  logic [CH-1:0]   ej,
    output logic            pe_rst,
    output logic            inj_en,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [IF_W-1:0] in_flight,
    output logic [IF_W-1:0] in_flight_max
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int PC_W  = $clog2(CH + 1);
    localparam int SUM_W = IF_W + PC_W + 2;
    localparam int MAX_A = (RST_CYC > RUN_CYC) ? RST_CYC : RUN_CYC;
    localparam int MAXC  = (MAX_A > DRAIN_MAX) ? MAX_A : DRAIN_MAX;
    localparam int CNT_W = $clog2(MAXC + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IF_W-1:0]   in_flight_q, in_flight_d;
    logic              err_q, err_d;
    logic              pe_rst_q, pe_rst_d;
    logic              inj_en_q, inj_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
`ifdef NOC_RUN_STATS_EN
    logic [IF_W-1:0]   in_flight_max_q, in_flight_max_d;
`endif

    logic [PC_W-1:0]         pc_inj, pc_ej;
    logic signed [SUM_W-1:0] sum, if_max;
    logic                    under, over, drain_err;
    logic [IF_W-1:0]         upd;

    // Net change in occupancy this cycle, saturated to the counter range
    always_comb begin
        pc_inj = '0;
        pc_ej  = '0;
        for (int i = 0; i < CH; i++) begin
            pc_inj = pc_inj + PC_W'(inj[i]);
            pc_ej  = pc_ej + PC_W'(ej[i]);
        end
        if_max = signed'(SUM_W'({IF_W{1'b1}}));
        sum    = signed'(SUM_W'(in_flight_q)) + signed'(SUM_W'(pc_inj))
                 - signed'(SUM_W'(pc_ej));
        under  = sum[SUM_W-1];
        over   = !under && (sum > if_max);
        if (under) begin
            upd = '0;
        end else if (over) begin
            upd = '1;
        end else begin
            upd = sum[IF_W-1:0];
        end
        drain_err = err_q || under || over || (|inj);
    end

    // Run sequencing, occupancy update and verdict; outputs follow next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_flight_d = in_flight_q;
        err_d       = err_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
`ifdef NOC_RUN_STATS_EN
        in_flight_max_d = in_flight_max_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RESET;
                    cnt_d       = '0;
                    in_flight_d = '0;
                    err_d       = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
`ifdef NOC_RUN_STATS_EN
                    in_flight_max_d = '0;
`endif
                end
            end
            S_RESET: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                in_flight_d = upd;
                err_d       = err_q || under || over;
`ifdef NOC_RUN_STATS_EN
                if (upd > in_flight_max_q) in_flight_max_d = upd;
`endif
                if (cnt_q == CNT_W'(RUN_CYC - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                in_flight_d = upd;
                err_d       = drain_err;
`ifdef NOC_RUN_STATS_EN
                if (upd > in_flight_max_q) in_flight_max_d = upd;
`endif
                if (upd == '0) begin
                    state_d   = S_DONE;
                    pass_d    = !drain_err;
                    timeout_d = 1'b0;
                end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
                    state_d   = S_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pe_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
        inj_en_d = (state_d == S_RUN);
        busy_d   = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d   = (state_d == S_DONE);
    end

    // State and registered outputs; reset abandons any run in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_flight_q <= '0;
            err_q       <= 1'b0;
            pe_rst_q    <= 1'b1;
            inj_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef NOC_RUN_STATS_EN
            in_flight_max_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
            pe_rst_q    <= pe_rst_d;
            inj_en_q    <= inj_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
`ifdef NOC_RUN_STATS_EN
            in_flight_max_q <= in_flight_max_d;
`endif
        end
    end

    assign pe_rst    = pe_rst_q;
    assign inj_en    = inj_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign in_flight = in_flight_q;
`ifdef NOC_RUN_STATS_EN
    assign in_flight_max = in_flight_max_q;
`else
    assign in_flight_max = '0;
`endif

endmodule

// File: doc/noc_run_ctrl.md
NOC_RUN_CTRL -- requirements
Module: noc_run_ctrl

Interface
REQ-001 SHALL have parameter CH, default 16, meaning number of torus PE channels (X_DIM*Y_DIM), 1..64.
REQ-002 SHALL have parameter RST_CYC, default 2, meaning number of cycles pe_rst is held high, >=1.
REQ-003 SHALL have parameter RUN_CYC, default 1600, meaning number of injection-phase cycles (MEM_D*X_DIM*Y_DIM*MAX_RATE), >=1.
REQ-004 SHALL have parameter DRAIN_MAX, default 256, meaning drain timeout in cycles, >=1.
REQ-005 SHALL have parameter IF_W, default 16, meaning in-flight counter width.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic rises on posedge clk.
REQ-007 SHALL have port rst, input, 1, meaning reset, synchronous and active-low.
REQ-008 SHALL have port start, input, 1, meaning a level-or-pulse request to begin a run; sampled only in IDLE.
REQ-009 SHALL have port inj, input, CH, meaning one-cycle pulse per channel when a PE packet is accepted into the NoC.
REQ-010 SHALL have port ej, input, CH, meaning one-cycle pulse per channel when a packet leaves the NoC at its destination.
REQ-011 SHALL have port pe_rst, output, 1, meaning active-high reset driven to the torus and PEs.
REQ-012 SHALL have port inj_en, output, 1, meaning injection permission to all PEs.
REQ-013 SHALL have port busy, output, 1, meaning the FSM is not in IDLE or DONE.
REQ-014 SHALL have port done, output, 1, meaning the FSM is in DONE.
REQ-015 SHALL have ports pass and timeout, outputs, 1 each, meaning run verdicts, valid while done=1.
REQ-016 SHALL have port in_flight, output, IF_W, meaning the live count of packets inside the NoC.
REQ-017 SHALL have port in_flight_max, output, IF_W, meaning the peak in_flight value (see REQ-033).

Function
REQ-018 SHALL implement FSM states IDLE, RESET, RUN, DRAIN, DONE.
REQ-019 SHALL move IDLE->RESET on start=1; in RESET, pe_rst=1 for exactly RST_CYC cycles, then RESET->RUN.
REQ-020 SHALL assert inj_en=1 only in RUN, for exactly RUN_CYC consecutive cycles, then RUN->DRAIN.
REQ-021 SHALL clear in_flight, the error flag and the drain counter on the IDLE->RESET transition.
REQ-022 SHALL, every cycle in RUN and DRAIN, update in_flight <= in_flight + popcount(inj) - popcount(ej), with both popcounts applied in the same cycle.
REQ-023 SHALL, in DRAIN, move to DONE with pass=1, timeout=0 on the first cycle in which the updated in_flight is 0 and the error flag is clear.
REQ-024 SHALL, in DRAIN, move to DONE with timeout=1, pass=0 when DRAIN_MAX cycles elapse with in_flight != 0.
REQ-025 SHALL set the sticky error flag (forcing pass=0) on any of: an inj bit high in DRAIN; a computed result below 0; a computed result above 2^IF_W-1. In each case in_flight saturates at 0 or 2^IF_W-1.
REQ-026 SHALL ignore inj and ej in IDLE, RESET and DONE.
REQ-027 SHALL hold DONE and its verdicts until start=1, then go DONE->RESET, starting a new run.
REQ-028 SHALL ignore start in RESET, RUN and DRAIN.

Reset
REQ-029 SHALL, when rst=0 at a posedge, enter IDLE with pe_rst=1, inj_en=0, busy=0, done=0, pass=0, timeout=0, in_flight=0, in_flight_max=0.
REQ-030 SHALL hold pe_rst=1 in IDLE, so the NoC stays reset until a run starts.
REQ-031 SHALL, on reset in the middle of any state, abandon the run within that cycle, with no partial verdict.

Configuration
REQ-032 SHALL gate peak tracking with the macro NOC_RUN_STATS_EN.
REQ-033 SHALL, when NOC_RUN_STATS_EN is defined, set in_flight_max <= max(in_flight_max, updated in_flight) every RUN/DRAIN cycle, clear it on IDLE->RESET, and hold it in DONE.
REQ-034 SHALL, when NOC_RUN_STATS_EN is undefined, drive in_flight_max as constant 0 and synthesise no comparator or register for it.

Verification
REQ-035 SHALL cover: CH=4, RST_CYC=2, RUN_CYC=10; start pulse with no traffic -> pe_rst high 2 cycles, inj_en high exactly 10 cycles, then done=1, pass=1 one cycle into DRAIN.
REQ-036 SHALL cover: inj=4'b1111 on one RUN cycle, ej=4'b0011 then 4'b1100 on the next two cycles -> in_flight goes 4,2,0; pass=1; in_flight_max=4 with the macro defined, 0 without.
REQ-037 SHALL cover: simultaneous inj=4'b0001 and ej=4'b0001 with in_flight=1 -> in_flight stays 1.
REQ-038 SHALL cover: DRAIN_MAX=8 and one packet never ejected -> done after 8 DRAIN cycles, timeout=1, pass=0, in_flight=1.
REQ-039 SHALL cover: ej=4'b0001 with in_flight=0 -> in_flight stays 0, error set, final pass=0.
REQ-040 SHALL cover: rst=0 in RUN with in_flight=3 -> next cycle IDLE, in_flight=0, inj_en=0, pe_rst=1; a later start runs a clean pass.
